l2_port_scheduler: RTL and testbench

- Shares the single L2 request port between three line-sized requesters: L1 instruction cache miss path (read-only), L1 data cache miss/writeback path (read/write), and a next-line prefetcher (read-only, lowest priority, droppable).
- Sits between the L1 caches/prefetcher and L2cache.
- Only one L2 transaction is ever outstanding.
- I and D are served round-robin. The prefetcher is served only when I and D are idle, and it is dropped after a timeout.

---
 rtl/l2_port_scheduler_if.sv | 47 ++++
 rtl/l2_port_scheduler.sv | 128 ++++++++++++
 tb/tb_l2_port_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_port_scheduler_if.sv
// Bundle of requester-side and L2-side signals around the L2 port scheduler.
// slave = the scheduler itself, master = the environment (L1s, prefetcher, L2).
interface l2_port_scheduler_if #(
  parameter int WIDTH      = 256,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [WIDTH-1:0]      i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [WIDTH-1:0]      d_wdata;
  logic [WIDTH-1:0]      d_rdata;
  logic                  d_resp;

  logic                  p_read;
  logic [ADDR_WIDTH-1:0] p_address;
  logic [WIDTH-1:0]      p_rdata;
  logic                  p_resp;
  logic                  pf_drop;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WIDTH-1:0]      mem_wdata;
  logic                  mem_resp;
  logic [WIDTH-1:0]      mem_rdata;

  logic                  busy;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           p_read, p_address, mem_resp, mem_rdata,
    output i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp, pf_drop,
           mem_read, mem_write, mem_address, mem_wdata, busy
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           p_read, p_address, mem_resp, mem_rdata,
    input  i_rdata, i_resp, d_rdata, d_resp, p_rdata, p_resp, pf_drop,
           mem_read, mem_write, mem_address, mem_wdata, busy
  );
endinterface

// File: rtl/l2_port_scheduler.sv
// Single-outstanding L2 port arbiter: I/D round-robin, prefetch only when both
// are idle, and a waiting prefetch is discarded after PF_TIMEOUT cycles.
module l2_port_scheduler #(
  parameter int WIDTH      = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int PF_TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  l2_port_scheduler_if.slave  bus
);

  localparam int             PW       = $clog2(PF_TIMEOUT + 1);
  localparam logic [PW-1:0]  PF_LIMIT = PW'(PF_TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, GRANT_P} state_t;

  state_t                state_q, state_d;
  logic                  last_id_q, last_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [PW-1:0]         pf_wait_q, pf_wait_d;

  logic                  d_req;
  logic                  pf_drop_c;
  logic                  grant_p;

  always_comb begin
    d_req     = bus.d_read | bus.d_write;
    // A prefetch already holding the port is never discarded.
    pf_drop_c = bus.p_read && (state_q != GRANT_P) && (pf_wait_q == PF_LIMIT);
    state_d   = state_q;
    last_id_d = last_id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    grant_p   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_read && (!d_req || last_id_q)) begin
          state_d = GRANT_I;
          addr_d  = bus.i_address;
          write_d = 1'b0;
        end else if (d_req) begin
          state_d = GRANT_D;
          addr_d  = bus.d_address;
          wdata_d = bus.d_wdata;
          write_d = bus.d_write;
        end else if (bus.p_read && !pf_drop_c) begin
          state_d = GRANT_P;
          addr_d  = bus.p_address;
          write_d = 1'b0;
          grant_p = 1'b1;
        end
      end
      GRANT_I: begin
        if (bus.mem_resp) begin
          state_d   = IDLE;
          last_id_d = 1'b0;
        end
      end
      GRANT_D: begin
        if (bus.mem_resp) begin
          state_d   = IDLE;
          last_id_d = 1'b1;
        end
      end
      GRANT_P: begin
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.p_read && !grant_p && (state_q != GRANT_P) && !pf_drop_c)
      pf_wait_d = pf_wait_q + PW'(1);
    else
      pf_wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_id_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      pf_wait_q <= '0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      pf_wait_q <= pf_wait_d;
    end
  end

  // Return path indexed 0 = I, 1 = D, 2 = P; only the owner sees data, and only with mem_resp.
  logic [2:0]       owner;
  logic [2:0]       resp_vec;
  logic [WIDTH-1:0] rdata_vec [3];

  assign owner = {state_q == GRANT_P, state_q == GRANT_D, state_q == GRANT_I};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ret
      assign resp_vec[gi]  = owner[gi] & bus.mem_resp;
      assign rdata_vec[gi] = resp_vec[gi] ? bus.mem_rdata : '0;
    end
  endgenerate

  assign bus.i_resp      = resp_vec[0];
  assign bus.d_resp      = resp_vec[1];
  assign bus.p_resp      = resp_vec[2];
  assign bus.i_rdata     = rdata_vec[0];
  assign bus.d_rdata     = rdata_vec[1];
  assign bus.p_rdata     = rdata_vec[2];
  assign bus.pf_drop     = pf_drop_c;

  assign bus.mem_read    = owner[0] | owner[2] | (owner[1] & ~write_q);
  assign bus.mem_write   = owner[1] & write_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed and randomized checks of l2_port_scheduler against a transaction-level
// model: service order from the round-robin/priority rules, latched address/data.
module tb_l2_port_scheduler;
  localparam int W  = 256;
  localparam int AW = 32;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ntx    = 0;
  int   last_m = 1;      // model: 0 = I served last, 1 = D served last
  int   drops  = 0;

  l2_port_scheduler_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  l2_port_scheduler #(.WIDTH(W), .ADDR_WIDTH(AW), .PF_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] v;
    for (int k = 0; k < W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
    bus.p_read = 1'b0; bus.p_address = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    last_m = 1;
    #1;
  endtask

  // One transaction, starting in the IDLE cycle where the winner's request is visible.
  task automatic do_txn(input int who, input logic wr, input logic [AW-1:0] addr,
                        input logic [W-1:0] wd, input int lat, input logic [W-1:0] rd,
                        input logic scramble);
    logic [2:0] exp_resp;
    chk1("idle_busy", bus.busy, 1'b0);
    chk1("idle_mem_read", bus.mem_read, 1'b0);
    chk1("idle_mem_write", bus.mem_write, 1'b0);
    tick();
    if (scramble) begin
      bus.i_address = $urandom;
      bus.d_address = 32'h0000_3000;
      bus.p_address = $urandom;
      bus.d_wdata   = rand_line();
    end
    #1;
    chk1("grant_busy", bus.busy, 1'b1);
    chk1("grant_mem_read", bus.mem_read, ~wr);
    chk1("grant_mem_write", bus.mem_write, wr);
    chkw("grant_mem_address", W'(bus.mem_address), W'(addr));
    if (wr) chkw("grant_mem_wdata", bus.mem_wdata, wd);
    for (int c = 0; c < lat; c++) begin
      tick();
      #1;
      chk1("hold_mem_read", bus.mem_read, ~wr);
      chk1("hold_mem_write", bus.mem_write, wr);
      chkw("hold_no_resp", W'({bus.p_resp, bus.d_resp, bus.i_resp}), '0);
    end
    bus.mem_rdata = rd;
    bus.mem_resp  = 1'b1;
    #1;
    exp_resp = 3'b001 << who;
    chkw("resp_vec", W'({bus.p_resp, bus.d_resp, bus.i_resp}), W'(exp_resp));
    chkw("i_rdata", bus.i_rdata, (who == 0) ? rd : '0);
    chkw("d_rdata", bus.d_rdata, (who == 1) ? rd : '0);
    chkw("p_rdata", bus.p_rdata, (who == 2) ? rd : '0);
    chk1("txn_pf_drop", bus.pf_drop, 1'b0);
    $display("txn %0d: owner=%s op=%s addr=%h latency=%0d", ntx,
             (who == 0) ? "I" : (who == 1) ? "D" : "P", wr ? "write" : "read", addr, lat);
    ntx++;
    tick();
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    if (who == 0) bus.i_read = 1'b0;
    if (who == 1) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    if (who == 2) bus.p_read = 1'b0;
    if (who < 2) last_m = who;
    #1;
  endtask

  // Expected address/op/data come from the requester's stimulus at grant time.
  task automatic serve(input int who, input int lat, input logic scramble);
    if (who == 0)      do_txn(0, 1'b0, bus.i_address, '0, lat, rand_line(), scramble);
    else if (who == 1) do_txn(1, bus.d_write, bus.d_address, bus.d_wdata, lat, rand_line(), scramble);
    else               do_txn(2, 1'b0, bus.p_address, '0, lat, rand_line(), scramble);
  endtask

  initial begin
    logic [W-1:0] line_ab;
    logic [W-1:0] line_55;
    int first;
    logic wi, wd_, dw;
    line_ab = {32{8'hAB}};
    line_55 = {32{8'h55}};

    // Reset state
    do_reset();
    tick();
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_mem_read", bus.mem_read, 1'b0);
    chk1("rst_mem_write", bus.mem_write, 1'b0);
    chkw("rst_mem_address", W'(bus.mem_address), '0);
    chkw("rst_mem_wdata", bus.mem_wdata, '0);
    chkw("rst_resps", W'({bus.p_resp, bus.d_resp, bus.i_resp, bus.pf_drop}), '0);

    // Single I read with same-cycle data
    bus.i_read = 1'b1; bus.i_address = 32'h0000_1000;
    #1;
    do_txn(0, 1'b0, 32'h0000_1000, '0, 0, line_ab, 1'b0);
    chk1("after_i_idle", bus.busy, 1'b0);

    // I and D together from reset: I first, then D write, then alternate again
    do_reset();
    bus.i_read = 1'b1; bus.i_address = 32'h0000_1100;
    bus.d_write = 1'b1; bus.d_address = 32'h0000_2000; bus.d_wdata = line_55;
    #1;
    do_txn(0, 1'b0, 32'h0000_1100, '0, 1, rand_line(), 1'b0);
    do_txn(1, 1'b1, 32'h0000_2000, line_55, 0, rand_line(), 1'b0);
    bus.i_read = 1'b1; bus.d_write = 1'b1;
    #1;
    do_txn(0, 1'b0, 32'h0000_1100, '0, 0, rand_line(), 1'b0);
    do_txn(1, 1'b1, 32'h0000_2000, line_55, 2, rand_line(), 1'b0);

    // D address changes during GRANT_D; latched value must stay
    bus.d_read = 1'b1; bus.d_address = 32'h0000_2040;
    #1;
    do_txn(1, 1'b0, 32'h0000_2040, '0, 2, rand_line(), 1'b1);

    // I + D + P at once: I (D served last), D, then P
    bus.i_read = 1'b1; bus.i_address = 32'h0000_6000;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_7000;
    bus.p_read = 1'b1; bus.p_address = 32'h0000_8000;
    #1;
    do_txn(0, 1'b0, 32'h0000_6000, '0, 0, rand_line(), 1'b0);
    do_txn(1, 1'b0, 32'h0000_7000, '0, 0, rand_line(), 1'b0);
    do_txn(2, 1'b0, 32'h0000_8000, '0, 0, rand_line(), 1'b0);

    // Prefetch starved by a continuously requesting I: drop after 16 waiting cycles
    bus.p_read = 1'b1; bus.p_address = 32'h0000_9000;
    bus.i_read = 1'b1; bus.i_address = 32'h0000_4000;
    for (int c = 0; c < 26; c++) begin
      if (c > 0) tick();
      if (c == 17) bus.p_read = 1'b0;
      bus.mem_resp  = (c % 2) == 1;
      bus.mem_rdata = rand_line();
      #1;
      chk1("starve_pf_drop", bus.pf_drop, c == 16);
      chk1("starve_p_resp", bus.p_resp, 1'b0);
      chk1("starve_busy", bus.busy, (c % 2) == 1);
      if (bus.pf_drop) drops++;
    end
    tick();
    bus.i_read = 1'b0; bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    last_m = 0;
    #1;
    chk1("starve_end_busy", bus.busy, 1'b0);
    chkw("starve_drop_count", W'(drops), W'(1));

    // Lone prefetch with slow L2: served, never dropped
    bus.p_read = 1'b1; bus.p_address = 32'h0000_A000;
    #1;
    do_txn(2, 1'b0, 32'h0000_A000, '0, 5, rand_line(), 1'b0);

    // Reset in the middle of GRANT_D
    bus.d_write = 1'b1; bus.d_address = 32'h0000_5000; bus.d_wdata = rand_line();
    tick();
    #1;
    chk1("pre_rst_mem_write", bus.mem_write, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.d_write = 1'b0;
    last_m = 1;
    #1;
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_mem_write", bus.mem_write, 1'b0);
    chk1("mid_rst_d_resp", bus.d_resp, 1'b0);
    bus.i_read = 1'b1; bus.i_address = 32'h0000_B000;
    bus.d_read = 1'b1; bus.d_address = 32'h0000_C000;
    #1;
    do_txn(0, 1'b0, 32'h0000_B000, '0, 1, rand_line(), 1'b0);
    do_txn(1, 1'b0, 32'h0000_C000, '0, 1, rand_line(), 1'b0);

    // Randomized rounds: order follows the round-robin rule, P only when alone
    for (int r = 0; r < 40; r++) begin
      wi  = 1'($urandom_range(0, 1));
      wd_ = 1'($urandom_range(0, 1));
      dw  = 1'($urandom_range(0, 1));
      bus.i_address = $urandom; bus.d_address = $urandom; bus.p_address = $urandom;
      bus.d_wdata   = rand_line();
      bus.i_read    = wi;
      bus.d_read    = wd_ & ~dw;
      bus.d_write   = wd_ & dw;
      bus.p_read    = ~wi & ~wd_;
      #1;
      if (wi && wd_) begin
        first = (last_m == 1) ? 0 : 1;
        serve(first, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        serve(1 - first, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (wi) begin
        serve(0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (wd_) begin
        serve(1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        serve(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
